// File: rtl/ser_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ser_add_pkg
//  Description : Shared definitions for the bit-serial adder and its
//                sequencing controller: datapath width, bit-counter width
//                and the controller state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ser_add_pkg;

  // Datapath width; the serial adder and its controller must agree on it.
  localparam int SER_W     = 16;
  // Enough bits to count SER_W bit-times (0..SER_W-1).
  localparam int SER_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } ser_add_state_t;

endpackage
`default_nettype wire

// File: rtl/ser_add.sv
`default_nettype none
// ============================================================================
//  Module      : ser_add
//  Description : Bit-serial adder datapath. Two operand shift registers and
//                a carry flop; one sum bit per clock, LSB first.
//  Ports       : clk   - clock
//                reset - synchronous active-high clear of operands and carry
//                mode  - 1: parallel-load in1/in2 and clear carry
//                        0: shift one bit-time
//                in1   - operand A for parallel load
//                in2   - operand B for parallel load
//                sum   - current sum bit (valid while shifting)
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_add
  import ser_add_pkg::*;
#(
  parameter int W = SER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         sum
);

  logic [W-1:0] sh_a;
  logic [W-1:0] sh_b;
  logic         cy;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a <= '0;
      sh_b <= '0;
      cy   <= 1'b0;
    end else if (mode) begin
      sh_a <= in1;
      sh_b <= in2;
      cy   <= 1'b0;
    end else begin
      sh_a <= {1'b0, sh_a[W-1:1]};
      sh_b <= {1'b0, sh_b[W-1:1]};
      cy   <= (sh_a[0] & sh_b[0]) | (cy & (sh_a[0] ^ sh_b[0]));
    end
  end

  // Full-adder sum of the current LSBs and the carry from the previous bit.
  assign sum = sh_a[0] ^ sh_b[0] ^ cy;

endmodule
`default_nettype wire

// File: rtl/ser_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ser_add_seq
//  Description : Sequencing controller around the bit-serial adder. Accepts
//                an operand pair, clears and loads the datapath, clocks it
//                for W bit-times, reassembles the sum and returns sum, carry
//                and signed overflow over a valid/ready response channel.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                req_valid/req_ready  - request handshake, operands a, b
//                rsp_valid/rsp_ready  - response handshake
//                sum, carry, ovf      - result (valid while rsp_valid)
//                busy                 - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_add_seq
  import ser_add_pkg::*;
#(
  parameter int W = SER_W   // only SER_W is supported by the datapath
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         ovf,
  output logic         busy
);

  ser_add_state_t       state;
  logic [W-1:0]         op_a;
  logic [W-1:0]         op_b;
  logic [W-1:0]         res;
  logic [SER_CNT_W-1:0] bitcnt;

  logic                 dp_reset;
  logic                 dp_mode;
  logic                 dp_sum;

  // The CLEAR cycle resets the datapath so LOAD never sees a stale carry.
  assign dp_reset = reset | (state == ST_CLEAR);
  assign dp_mode  = (state == ST_LOAD);

  ser_add #(
    .W (W)
  ) u_ser_add (
    .clk   (clk),
    .reset (dp_reset),
    .mode  (dp_mode),
    .in1   (op_a),
    .in2   (op_b),
    .sum   (dp_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      bitcnt    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_a      <= a;
            op_b      <= b;
            state     <= ST_CLEAR;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          bitcnt <= '0;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // LSB-first stream: each new bit enters at the top and walks down.
          res    <= {dp_sum, res[W-1:1]};
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == SER_CNT_W'(W - 1)) begin
            state     <= ST_DONE;
            rsp_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Flags recovered from the operand MSBs and the result MSB: a carry out of
  // the top bit happened iff both MSBs were set, or exactly one was set and
  // the incoming carry cleared the result MSB.
  assign sum   = res;
  assign carry = (op_a[W-1] & op_b[W-1]) | ((op_a[W-1] ^ op_b[W-1]) & ~res[W-1]);
  assign ovf   = (op_a[W-1] == op_b[W-1]) & (res[W-1] != op_a[W-1]);

endmodule
`default_nettype wire
